// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the five-stage MIPS core.
// Imported by the fetch sequencer and its skid buffer.
package cpu_pkg;

  localparam int WORD = 32;

  localparam logic [WORD-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [WORD-1:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_st_t;

  function automatic logic [WORD-1:0] walign(
    input logic [WORD-1:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that returned while
// the pipeline was stalled.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clr,
  input  logic [WORD-1:0] i_instr,
  input  logic [WORD-1:0] i_pc,
  input  logic [WORD-1:0] i_pc4,
  output logic            o_valid,
  output logic [WORD-1:0] o_instr,
  output logic [WORD-1:0] o_pc,
  output logic [WORD-1:0] o_pc4
);

  logic            r_valid;
  logic [WORD-1:0] r_instr;
  logic [WORD-1:0] r_pc;
  logic [WORD-1:0] r_pc4;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, IF/ID register, imem handshake,
// delay-slot redirects, stall skid and exception vectoring.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic [31:0] epc
);

  import cpu_pkg::*;

  fetch_st_t       r_state;
  logic            r_req;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_pc;
  logic            r_rpend;
  logic [WORD-1:0] r_rpc;
  logic [WORD-1:0] r_instr;
  logic [WORD-1:0] r_pcd;
  logic [WORD-1:0] r_pc4d;
  logic            r_valid;
  logic [WORD-1:0] r_epc;

  logic            w_done;
  logic            w_redir;
  logic [WORD-1:0] w_pc4;
  logic [WORD-1:0] w_tgt;
  logic [WORD-1:0] w_nxt;
  logic            w_skid_ld;
  logic            w_skid_clr;
  logic            w_sk_v;
  logic [WORD-1:0] w_sk_instr;
  logic [WORD-1:0] w_sk_pc;
  logic [WORD-1:0] w_sk_pc4;

  assign w_done  = r_req & imem_ready;
  assign w_redir = redirect & ~stall;
  assign w_pc4   = r_pc + 32'd4;
  assign w_tgt   = w_redir ? walign(redirect_pc) : r_rpc;
  assign w_nxt   = (w_redir | r_rpend) ? w_tgt : w_pc4;

  assign w_skid_ld  = ~exc & (r_state == REQ) & w_done & stall;
  assign w_skid_clr = exc | ((r_state == HOLD) & ~stall);

  fetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_ld),
    .i_clr   (w_skid_clr),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .o_valid (w_sk_v),
    .o_instr (w_sk_instr),
    .o_pc    (w_sk_pc),
    .o_pc4   (w_sk_pc4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
      r_req   <= 1'b1;
      r_addr  <= walign(RESET_PC);
      r_pc    <= walign(RESET_PC);
      r_rpend <= 1'b0;
      r_rpc   <= '0;
      r_instr <= '0;
      r_pcd   <= '0;
      r_pc4d  <= '0;
      r_valid <= 1'b0;
      r_epc   <= '0;
    end else if (exc) begin
      r_epc   <= r_pcd;
      r_valid <= 1'b0;
      r_rpend <= 1'b0;
      r_pc    <= walign(EXC_VECTOR);
      // an unanswered request must finish before the vector fetch
      if (r_state != HOLD && !imem_ready) begin
        r_state <= DRAIN;
      end else begin
        r_state <= REQ;
        r_req   <= 1'b1;
        r_addr  <= walign(EXC_VECTOR);
      end
    end else begin
      unique case (r_state)
        REQ: begin
          if (w_done && !stall) begin
            r_instr <= imem_rdata;
            r_pcd   <= r_pc;
            r_pc4d  <= w_pc4;
            r_valid <= 1'b1;
            r_pc    <= w_nxt;
            r_addr  <= w_nxt;
            r_rpend <= 1'b0;
          end else if (w_done) begin
            r_state <= HOLD;
            r_req   <= 1'b0;
          end else if (w_redir) begin
            r_rpend <= 1'b1;
            r_rpc   <= walign(redirect_pc);
          end
        end
        HOLD: begin
          if (!stall) begin
            r_instr <= w_sk_instr;
            r_pcd   <= w_sk_pc;
            r_pc4d  <= w_sk_pc4;
            r_valid <= w_sk_v;
            r_pc    <= w_nxt;
            r_addr  <= w_nxt;
            r_rpend <= 1'b0;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            r_state <= REQ;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instr_d   = r_instr;
  assign pc_d      = r_pcd;
  assign pc4_d     = r_pc4d;
  assign valid_d   = r_valid;
  assign epc       = r_epc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a wait-state memory model and
// queue-based scoreboard for fetches, IF/ID loads and point checks.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic [31:0] epc;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc         (exc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc4_d       (pc4_d),
    .valid_d     (valid_d),
    .epc         (epc)
  );

  // memory: ready after ws cycles of an outstanding request
  int ws = 0;
  int cnt = 0;
  always @(posedge clk) begin
    if (reset || !imem_req || imem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign imem_ready = imem_req && (cnt >= ws);
  assign imem_rdata = imem_addr ^ KEY;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        dq[$];
  logic [31:0] ea[$];
  logic [31:0] ei[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done = 1'b0;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: return {31'd0, imem_req};
      1: return imem_addr;
      2: return {31'd0, valid_d};
      3: return pc_d;
      4: return pc4_d;
      5: return instr_d;
      6: return epc;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic void cmp(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic want(string nm, int sel, logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    dq.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : mon
    chk_t        c;
    logic [31:0] e;
    bit          pv;
    logic [31:0] pp;
    int          cyc;
    pv  = 1'b0;
    pp  = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || cyc > 400) begin
        if (!done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL watchdog: got %0d cycles required done", cyc);
        end
        cmp("addr_left", 32'(ea.size()), 32'd0);
        cmp("ifid_left", 32'(ei.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
      end
      while (dq.size() > 0) begin
        c = dq.pop_front();
        cmp(c.name, probe(c.sel), c.exp);
      end
      if (!reset && imem_req && imem_ready) begin
        if (ea.size() == 0) begin
          cmp("fetch_extra", imem_addr, 32'hxxxx_xxxx);
        end else begin
          e = ea.pop_front();
          cmp("fetch_addr", imem_addr, e);
        end
      end
      if (valid_d && (!pv || pc_d != pp)) begin
        if (ei.size() == 0) begin
          cmp("ifid_extra", pc_d, 32'hxxxx_xxxx);
        end else begin
          e = ei.pop_front();
          cmp("ifid_pc", pc_d, e);
          cmp("ifid_instr", instr_d, e ^ KEY);
          cmp("ifid_pc4", pc4_d, e + 32'd4);
        end
      end
      pv = valid_d;
      pp = pc_d;
    end
  end

  initial begin : stim
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exc         = 1'b0;
    tick();
    tick();
    want("rst_req", 0, 32'd1);
    want("rst_addr", 1, 32'h0000_3000);
    want("rst_valid", 2, 32'd0);
    want("rst_pc_d", 3, 32'd0);
    want("rst_pc4_d", 4, 32'd0);
    want("rst_instr", 5, 32'd0);
    want("rst_epc", 6, 32'd0);
    foreach (ea[i]) ea.delete(i);
    ea.push_back(32'h3000); ea.push_back(32'h3004);
    ea.push_back(32'h3008); ea.push_back(32'h300C);
    ei.push_back(32'h3000); ei.push_back(32'h3004);
    ei.push_back(32'h3008); ei.push_back(32'h300C);
    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ea.push_back(32'h3000); ea.push_back(32'h3004);
    ea.push_back(32'h3008); ea.push_back(32'h3100);
    ei.push_back(32'h3000); ei.push_back(32'h3004);
    ei.push_back(32'h3008); ei.push_back(32'h3100);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3103;
    tick();
    redirect = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ea.push_back(32'h3000); ea.push_back(32'h3004);
    ea.push_back(32'h3008); ea.push_back(32'h300C);
    ea.push_back(32'h3010); ea.push_back(32'h4180);
    ea.push_back(32'h4184); ea.push_back(32'h4180);
    ea.push_back(32'h4184); ea.push_back(32'h4188);
    ea.push_back(32'hFFFF_FFFC); ea.push_back(32'h0);
    ea.push_back(32'h4);
    ei.push_back(32'h3000); ei.push_back(32'h3004);
    ei.push_back(32'h3008); ei.push_back(32'h300C);
    ei.push_back(32'h4180); ei.push_back(32'h4180);
    ei.push_back(32'h4184); ei.push_back(32'h4188);
    ei.push_back(32'hFFFF_FFFC); ei.push_back(32'h0);
    tick();
    ws = 2;
    tick();
    tick();
    stall = 1'b1;
    want("ws_valid_old", 2, 32'd1);
    want("ws_pc_d_old", 3, 32'h3000);
    tick();
    want("stall_req0", 0, 32'd0);
    tick();
    want("stall_req1", 0, 32'd0);
    tick();
    stall = 1'b0;
    ws    = 0;
    want("stall_req2", 0, 32'd0);
    tick();
    want("unstall_req", 0, 32'd1);
    want("unstall_addr", 1, 32'h3008);
    tick();
    tick();
    ws = 3;
    tick();
    exc = 1'b1;
    tick();
    exc = 1'b0;
    want("exc_epc", 6, 32'h300C);
    want("exc_valid", 2, 32'd0);
    want("drain_req", 0, 32'd1);
    want("drain_addr", 1, 32'h3010);
    tick();
    ws = 0;
    tick();
    tick();
    exc         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    tick();
    exc      = 1'b0;
    redirect = 1'b0;
    want("exc2_epc", 6, 32'h4180);
    want("exc2_valid", 2, 32'd0);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    want("wrap_pc_d", 3, 32'hFFFF_FFFC);
    want("wrap_pc4_d", 4, 32'h0);
    tick();
    want("zero_pc4_d", 4, 32'h4);
    tick();
    done = 1'b1;
  end

endmodule
